reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- SYNC_STAGES, 2, reset-deassertion synchronizer depth (>=2)
- ADC_DELAY, 16, cycles from sequence start to io_adc_clk_rst release (>=1)
- CORE_DELAY, 32, cycles from ADC release to io_core_reset release (>=1)
- DSP_DELAY, 16, cycles from core release to io_dsp_reset release (>=1)
- UA_DELAY, 8, cycles from DSP release to io_ua_reset release (>=1)
- CNT_WIDTH, 8, delay counter width
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clock, in, 1, sole clock
- reset, in, 1, async active-high master reset
- io_soft_reset, in, 1, synchronous restart request, active-high
- io_hold, in, 1, freezes sequence progress while high
- io_adc_clk_rst, out, 1, ADC clock-domain reset, active-high
- io_core_reset, out, 1, core reset, active-high
- io_dsp_reset, out, 1, DSP reset, active-high
- io_ua_reset, out, 1, UART reset, active-high
- io_done, out, 1, high once all resets are released
- io_stage, out, 3, current FSM state encoding

Function
REQ-004 Elaboration SHALL fail if any *_DELAY < 1, SYNC_STAGES < 2, or any *_DELAY-1 does not fit in CNT_WIDTH bits.
REQ-005 Synchronizer: SYNC_STAGES flops SHALL be set to 1 asynchronously by reset and shift in 0 on each rising edge; sync_rst is the last stage.
REQ-006 FSM states/encodings: HOLD=0, WAIT_ADC=1, WAIT_CORE=2, WAIT_DSP=3, WAIT_UA=4, DONE=5; io_stage SHALL equal the state register.
REQ-007 HOLD -> WAIT_ADC SHALL occur on the first edge where sync_rst==0 and io_soft_reset==0; the counter SHALL be cleared on entry to each WAIT_* state.
REQ-008 In WAIT_x, the counter SHALL increment each edge with io_hold low; when counter==x_DELAY-1 and io_hold low, the FSM SHALL advance to the next state: WAIT_ADC->WAIT_CORE->WAIT_DSP->WAIT_UA->DONE.
REQ-009 Outputs SHALL be registered and change on the same edge as the state transition: io_adc_clk_rst high only in HOLD and WAIT_ADC; io_core_reset high in HOLD..WAIT_CORE; io_dsp_reset high in HOLD..WAIT_DSP; io_ua_reset high in HOLD..WAIT_UA; io_done high only in DONE.
REQ-010 While io_hold is high in a WAIT_* state, the counter and state SHALL be frozen; io_hold SHALL have no effect in HOLD or DONE.
REQ-011 io_soft_reset sampled high in any state SHALL move the FSM to HOLD at that edge, asserting all four resets and deasserting io_done; it SHALL take priority over io_hold and over a coincident counter-terminal transition.
REQ-012 The FSM SHALL remain in HOLD while io_soft_reset stays high; the synchronizer SHALL NOT be re-armed by io_soft_reset.
REQ-013 DONE SHALL be absorbing until reset or io_soft_reset.
REQ-014 Resets SHALL never be released out of order, and no two resets SHALL release on the same edge.

Reset
REQ-015 Assertion of reset SHALL, without a clock edge, set io_adc_clk_rst, io_core_reset, io_dsp_reset, and io_ua_reset to 1, io_done to 0, io_stage to 0, the counter to 0, and all synchronizer flops to 1.
REQ-016 Reset asserted mid-sequence SHALL abort the sequence immediately per REQ-015.
REQ-017 Deassertion of reset SHALL take effect only through the synchronizer.

Verification
REQ-018 Defaults, reset falls before edge 1 -> WAIT_ADC entered at edge 3; io_adc_clk_rst falls at edge 19, io_core_reset at 51, io_dsp_reset at 67, io_ua_reset and io_done rise/fall at 75; io_stage sequence 0,1,2,3,4,5.
REQ-019 Defaults, io_hold high for 10 cycles inside WAIT_CORE -> io_core_reset release delayed to edge 61; later releases each shifted by 10.
REQ-020 In DONE, io_soft_reset pulsed high for 1 cycle at edge k -> all resets high and io_done low after edge k; WAIT_ADC at k+1; io_adc_clk_rst falls at k+17.
REQ-021 io_soft_reset high on the same edge the WAIT_DSP counter hits 15 with io_hold low -> state HOLD, not WAIT_UA; io_dsp_reset stays high.
REQ-022 reset asserted asynchronously between edges while in WAIT_UA -> all resets high and io_stage 0 before the next edge; full sequence repeats with timing per REQ-018.
REQ-023 All delays set to 1, SYNC_STAGES 2 -> releases on edges 4, 5, 6, 7; no two resets release on the same edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Releases four subsystem resets in a fixed order (ADC clock domain, core,
// DSP, UART) with a programmable number of cycles between each release. A
// master reset is accepted asynchronously. Its deassertion only reaches the
// sequencer after passing through a reset synchronizer. A synchronous soft
// reset restarts the sequence without re-arming the synchronizer. A hold input
// freezes progress while the sequencer is waiting on a delay.
//
// Parameters
//   SYNC_STAGES  depth of the reset-deassertion synchronizer (>= 2)
//   ADC_DELAY    cycles from sequence start to ADC clock-reset release (>= 1)
//   CORE_DELAY   cycles from ADC release to core reset release (>= 1)
//   DSP_DELAY    cycles from core release to DSP reset release (>= 1)
//   UA_DELAY     cycles from DSP release to UART reset release (>= 1)
//   CNT_WIDTH    delay counter width; every *_DELAY-1 must fit
//
// Ports
//   clock           sole clock
//   reset           asynchronous active-high master reset
//   io_soft_reset   synchronous restart request, active-high
//   io_hold         freezes the delay counter and state while waiting
//   io_adc_clk_rst  ADC clock-domain reset, active-high
//   io_core_reset   core reset, active-high
//   io_dsp_reset    DSP reset, active-high
//   io_ua_reset     UART reset, active-high
//   io_done         high once every reset has been released
//   io_stage        current state encoding
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int ADC_DELAY   = 16,
  parameter int CORE_DELAY  = 32,
  parameter int DSP_DELAY   = 16,
  parameter int UA_DELAY    = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_soft_reset,
  input  logic       io_hold,
  output logic       io_adc_clk_rst,
  output logic       io_core_reset,
  output logic       io_dsp_reset,
  output logic       io_ua_reset,
  output logic       io_done,
  output logic [2:0] io_stage
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  localparam longint CntSpan = longint'(1) << CNT_WIDTH;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_width
    $fatal(1, "reset_sequencer: CNT_WIDTH must be >= 1");
  end
  if (ADC_DELAY < 1 || CORE_DELAY < 1 || DSP_DELAY < 1 || UA_DELAY < 1) begin : g_bad_delay
    $fatal(1, "reset_sequencer: every *_DELAY must be >= 1");
  end
  if (longint'(ADC_DELAY) - 1 >= CntSpan) begin : g_bad_adc_fit
    $fatal(1, "reset_sequencer: ADC_DELAY-1 does not fit in CNT_WIDTH bits");
  end
  if (longint'(CORE_DELAY) - 1 >= CntSpan) begin : g_bad_core_fit
    $fatal(1, "reset_sequencer: CORE_DELAY-1 does not fit in CNT_WIDTH bits");
  end
  if (longint'(DSP_DELAY) - 1 >= CntSpan) begin : g_bad_dsp_fit
    $fatal(1, "reset_sequencer: DSP_DELAY-1 does not fit in CNT_WIDTH bits");
  end
  if (longint'(UA_DELAY) - 1 >= CntSpan) begin : g_bad_ua_fit
    $fatal(1, "reset_sequencer: UA_DELAY-1 does not fit in CNT_WIDTH bits");
  end

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StWaitAdc  = 3'd1,
    StWaitCore = 3'd2,
    StWaitDsp  = 3'd3,
    StWaitUa   = 3'd4,
    StDone     = 3'd5
  } state_e;

  // Terminal counter values: a state with delay D spends exactly D edges.
  localparam logic [CNT_WIDTH-1:0] AdcLast  = CNT_WIDTH'(ADC_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] CoreLast = CNT_WIDTH'(CORE_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] DspLast  = CNT_WIDTH'(DSP_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] UaLast   = CNT_WIDTH'(UA_DELAY - 1);

  // Successor of each waiting state in the release order.
  function automatic state_e next_wait(input state_e s);
    state_e n;
    case (s)
      StWaitAdc:  n = StWaitCore;
      StWaitCore: n = StWaitDsp;
      StWaitDsp:  n = StWaitUa;
      default:    n = StDone;
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Reset-deassertion synchronizer
  // ---------------------------------------------------------------------------
  // Set asynchronously, drains one zero per edge; the sequencer only leaves
  // HOLD once the last stage has cleared.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_rst;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign w_sync_rst = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Sequencer FSM and delay counter
  // ---------------------------------------------------------------------------
  state_e                 r_state;
  state_e                 w_state_d;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_d;
  logic [CNT_WIDTH-1:0]   w_last;

  always_comb begin
    w_last = '0;
    case (r_state)
      StWaitAdc:  w_last = AdcLast;
      StWaitCore: w_last = CoreLast;
      StWaitDsp:  w_last = DspLast;
      StWaitUa:   w_last = UaLast;
      default:    w_last = '0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (io_soft_reset) begin
      // Soft reset wins over hold and over a coincident terminal count.
      w_state_d = StHold;
      w_cnt_d   = '0;
    end else begin
      case (r_state)
        StHold: begin
          if (!w_sync_rst) begin
            w_state_d = StWaitAdc;
            w_cnt_d   = '0;
          end
        end
        StWaitAdc, StWaitCore, StWaitDsp, StWaitUa: begin
          if (!io_hold) begin
            if (r_cnt == w_last) begin
              w_state_d = next_wait(r_state);
              w_cnt_d   = '0;
            end else begin
              w_cnt_d = r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        StDone: begin
          // Absorbing until reset or soft reset.
        end
        default: begin
          w_state_d = StHold;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StHold;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // Decoded from the next state so they change on the same edge as the state.
  // Each reset is a superset of the one released before it, which makes an
  // out-of-order release structurally impossible.
  logic w_adc_d;
  logic w_core_d;
  logic w_dsp_d;
  logic w_ua_d;
  logic w_done_d;

  always_comb begin
    w_adc_d  = (w_state_d == StHold) || (w_state_d == StWaitAdc);
    w_core_d = w_adc_d  || (w_state_d == StWaitCore);
    w_dsp_d  = w_core_d || (w_state_d == StWaitDsp);
    w_ua_d   = w_dsp_d  || (w_state_d == StWaitUa);
    w_done_d = (w_state_d == StDone);
  end

  logic r_adc;
  logic r_core;
  logic r_dsp;
  logic r_ua;
  logic r_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_adc  <= 1'b1;
      r_core <= 1'b1;
      r_dsp  <= 1'b1;
      r_ua   <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_adc  <= w_adc_d;
      r_core <= w_core_d;
      r_dsp  <= w_dsp_d;
      r_ua   <= w_ua_d;
      r_done <= w_done_d;
    end
  end

  assign io_adc_clk_rst = r_adc;
  assign io_core_reset  = r_core;
  assign io_dsp_reset   = r_dsp;
  assign io_ua_reset    = r_ua;
  assign io_done        = r_done;
  assign io_stage       = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Drives two sequencers from the same stimulus: one with default delays and
// one with every delay set to 1. A timeline model predicts the outputs of both
// from the number of non-held cycles elapsed since the sequence started; the
// outputs are compared against it on every falling edge. Literal expectations
// at the documented release edges pin the model itself.
//
// Output vectors are packed as {stage[2:0], done, ua, dsp, core, adc}.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic clock;
  logic reset = 1'b0;
  logic io_soft_reset = 1'b0;
  logic io_hold = 1'b0;

  logic       d_adc, d_core, d_dsp, d_ua, d_done;
  logic [2:0] d_stage;
  logic       f_adc, f_core, f_dsp, f_ua, f_done;
  logic [2:0] f_stage;

  reset_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .io_soft_reset  (io_soft_reset),
    .io_hold        (io_hold),
    .io_adc_clk_rst (d_adc),
    .io_core_reset  (d_core),
    .io_dsp_reset   (d_dsp),
    .io_ua_reset    (d_ua),
    .io_done        (d_done),
    .io_stage       (d_stage)
  );

  reset_sequencer #(
    .SYNC_STAGES (2),
    .ADC_DELAY   (1),
    .CORE_DELAY  (1),
    .DSP_DELAY   (1),
    .UA_DELAY    (1),
    .CNT_WIDTH   (8)
  ) dut_fast (
    .clock          (clock),
    .reset          (reset),
    .io_soft_reset  (io_soft_reset),
    .io_hold        (io_hold),
    .io_adc_clk_rst (f_adc),
    .io_core_reset  (f_core),
    .io_dsp_reset   (f_dsp),
    .io_ua_reset    (f_ua),
    .io_done        (f_done),
    .io_stage       (f_stage)
  );

  logic [7:0] dut_vec;
  logic [7:0] fast_vec;
  assign dut_vec  = {d_stage, d_done, d_ua, d_dsp, d_core, d_adc};
  assign fast_vec = {f_stage, f_done, f_ua, f_dsp, f_core, f_adc};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model
  // ---------------------------------------------------------------------------
  // A sequence is "started" once the synchronized reset has cleared and no soft
  // reset is pending; from then on every edge without hold advances an elapsed
  // count. Each reset is released once the elapsed count reaches the running
  // sum of the delays up to and including its own.
  localparam int SyncStages = 2;
  int dly [2][4] = '{'{16, 32, 16, 8}, '{1, 1, 1, 1}};

  bit m_started [2] = '{1'b0, 1'b0};
  int m_active  [2] = '{0, 0};
  int m_sync    = 0;

  function automatic int total_of(input int i);
    return dly[i][0] + dly[i][1] + dly[i][2] + dly[i][3];
  endfunction

  function automatic logic [7:0] model_vec(input int i);
    int c0, c1, c2, c3, stage, a;
    c0 = dly[i][0];
    c1 = c0 + dly[i][1];
    c2 = c1 + dly[i][2];
    c3 = c2 + dly[i][3];
    a  = m_active[i];
    if (!m_started[i]) return 8'h0F;
    stage = 1 + int'(a >= c0) + int'(a >= c1) + int'(a >= c2) + int'(a >= c3);
    return {3'(stage), a >= c3, a < c3, a < c2, a < c1, a < c0};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sync <= 0;
      for (int i = 0; i < 2; i++) begin
        m_started[i] <= 1'b0;
        m_active[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (io_soft_reset) begin
          m_started[i] <= 1'b0;
          m_active[i]  <= 0;
        end else if (!m_started[i]) begin
          if (m_sync >= SyncStages) begin
            m_started[i] <= 1'b1;
            m_active[i]  <= 0;
          end
        end else if (!io_hold && m_active[i] < total_of(i)) begin
          m_active[i] <= m_active[i] + 1;
        end
      end
      if (m_sync < 1000) m_sync <= m_sync + 1;
    end
  end

  always @(negedge clock) begin
    chk("dut_cycle", dut_vec, model_vec(0));
    chk("fast_cycle", fast_vec, model_vec(1));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus; ed counts rising edges since the last reset release.
  // ---------------------------------------------------------------------------
  int ed = 0;

  task automatic adv(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clock);
      ed++;
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset_state_dut", dut_vec, 8'h0F);
    chk("reset_state_fast", fast_vec, 8'h0F);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    ed = 0;

    // Power-on sequence, default and all-ones delays.
    adv(2);  chk("sync_hold_ed2", dut_vec, 8'h0F);
             chk("sync_hold_ed2_fast", fast_vec, 8'h0F);
    adv(1);  chk("wait_adc_ed3", dut_vec, 8'h2F);
             chk("wait_adc_ed3_fast", fast_vec, 8'h2F);
    adv(1);  chk("fast_adc_ed4", fast_vec, 8'h4E);
    adv(1);  chk("fast_core_ed5", fast_vec, 8'h6C);
    adv(1);  chk("fast_dsp_ed6", fast_vec, 8'h88);
    adv(1);  chk("fast_ua_ed7", fast_vec, 8'hB0);
    adv(11); chk("adc_held_ed18", dut_vec, 8'h2F);
    adv(1);  chk("adc_rel_ed19", dut_vec, 8'h4E);
    adv(31); chk("core_held_ed50", dut_vec, 8'h4E);
    adv(1);  chk("core_rel_ed51", dut_vec, 8'h6C);
    adv(15); chk("dsp_held_ed66", dut_vec, 8'h6C);
    adv(1);  chk("dsp_rel_ed67", dut_vec, 8'h88);
    adv(7);  chk("ua_held_ed74", dut_vec, 8'h88);
    adv(1);  chk("done_ed75", dut_vec, 8'hB0);

    // Hold has no effect once done.
    io_hold = 1'b1;
    adv(3);  chk("hold_in_done", dut_vec, 8'hB0);
    io_hold = 1'b0;

    // One-cycle soft reset from DONE at edge k=79.
    io_soft_reset = 1'b1;
    adv(1);  chk("soft_k", dut_vec, 8'h0F);
             chk("soft_k_fast", fast_vec, 8'h0F);
    io_soft_reset = 1'b0;
    adv(1);  chk("soft_k1_wait_adc", dut_vec, 8'h2F);
    adv(15); chk("soft_adc_held", dut_vec, 8'h2F);
    adv(1);  chk("soft_adc_rel_k17", dut_vec, 8'h4E);

    // Ten held cycles inside WAIT_CORE push every later release by ten.
    adv(5);
    io_hold = 1'b1;
    adv(10); chk("core_frozen", dut_vec, 8'h4E);
    io_hold = 1'b0;
    adv(26); chk("core_held_late", dut_vec, 8'h4E);
    adv(1);  chk("core_rel_shifted", dut_vec, 8'h6C);
    adv(15); chk("dsp_held_shifted", dut_vec, 8'h6C);
    adv(1);  chk("dsp_rel_shifted", dut_vec, 8'h88);
    adv(7);  chk("ua_held_shifted", dut_vec, 8'h88);
    adv(1);  chk("done_shifted", dut_vec, 8'hB0);

    // Soft reset held for several cycles keeps HOLD, then restarts.
    io_soft_reset = 1'b1;
    adv(3);  chk("soft_held_hold", dut_vec, 8'h0F);
    io_soft_reset = 1'b0;
    adv(1);  chk("restart_wait_adc", dut_vec, 8'h2F);

    // Soft reset coincident with the WAIT_DSP terminal count.
    adv(63); chk("dsp_before_term", dut_vec, 8'h6C);
    io_soft_reset = 1'b1;
    adv(1);  chk("soft_beats_term", dut_vec, 8'h0F);
    io_soft_reset = 1'b0;
    adv(1);  chk("restart2_wait_adc", dut_vec, 8'h2F);

    // Asynchronous reset while in WAIT_UA, between edges.
    adv(66); chk("in_wait_ua", dut_vec, 8'h88);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_dut", dut_vec, 8'h0F);
    chk("async_reset_fast", fast_vec, 8'h0F);
    @(negedge clock);
    reset = 1'b0;
    ed = 0;
    adv(3);  chk("re_wait_adc_ed3", dut_vec, 8'h2F);
    adv(16); chk("re_adc_rel_ed19", dut_vec, 8'h4E);
    adv(32); chk("re_core_rel_ed51", dut_vec, 8'h6C);
    adv(24); chk("re_done_ed75", dut_vec, 8'hB0);
    adv(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
